// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder: FSM state encoding
// and helpers that size the chunk counter.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter needs at least one bit even when the whole word fits in one chunk.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// Adds two WIDTH-bit operands plus carry-in, CHUNK bits per cycle, behind
// valid/ready handshakes; also reports two's-complement overflow.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CW         = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
    logic             chunk_co;

    assign chunk_x = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_y = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x  (chunk_x),
        .y  (chunk_y),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                psum_d[idx_q*CHUNK +: CHUNK] = chunk_s;
                carry_d = chunk_co;
                idx_d   = idx_q + CW'(1);
                if (idx_q == LAST_IDX) begin
                    // psum_d already holds the final chunk, so publish it directly.
                    sum_d   = psum_d;
                    cout_d  = chunk_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (psum_d[WIDTH-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder in three configurations: 16/4, 4/1
// (exhaustive) and 8/8 (single-chunk).
module tb_multicycle_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // DUT 0: WIDTH=16, CHUNK=4
    logic        iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0, cin0 = 1'b0, co0, of0;
    logic [15:0] a0 = '0, b0 = '0, s0;
    // DUT 1: WIDTH=4, CHUNK=1
    logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, cin1 = 1'b0, co1, of1;
    logic [3:0]  a1 = '0, b1 = '0, s1;
    // DUT 2: WIDTH=8, CHUNK=8
    logic        iv2 = 1'b0, ir2, ov2, ordy2 = 1'b0, cin2 = 1'b0, co2, of2;
    logic [7:0]  a2 = '0, b2 = '0, s2;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(cin0), .out_valid(ov0), .out_ready(ordy0), .sum(s0), .cout(co0),
        .overflow(of0)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(co1),
        .overflow(of1)
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .cin(cin2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .cout(co2),
        .overflow(of2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic c);
        case (d)
            0: begin iv0 = v; a0 = av;       b0 = bv;       cin0 = c; end
            1: begin iv1 = v; a1 = av[3:0];  b1 = bv[3:0];  cin1 = c; end
            default: begin iv2 = v; a2 = av[7:0]; b2 = bv[7:0]; cin2 = c; end
        endcase
    endtask

    task automatic set_ordy(input int d, input logic v);
        case (d)
            0: ordy0 = v;
            1: ordy1 = v;
            default: ordy2 = v;
        endcase
    endtask

    function automatic logic get_ov(input int d);
        case (d)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0: return ir0;
            1: return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int d);
        case (d)
            0: return s0;
            1: return {12'h000, s1};
            default: return {8'h00, s2};
        endcase
    endfunction

    function automatic logic get_cout(input int d);
        case (d)
            0: return co0;
            1: return co1;
            default: return co2;
        endcase
    endfunction

    function automatic logic get_ovf(input int d);
        case (d)
            0: return of0;
            1: return of1;
            default: return of2;
        endcase
    endfunction

    // One full handshake: issue operands, wait for the result, check it, drain it.
    task automatic xact(input int d, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic eo, input int elat, input string tag);
        int lat;
        check({tag, " in_ready_before"}, 32'(get_ir(d)), 32'd1);
        drive(d, 1'b1, av, bv, c);
        @(negedge clk);
        drive(d, 1'b0, 16'h0000, 16'h0000, 1'b0);
        lat = 0;
        while (!get_ov(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " sum"}, 32'(get_sum(d)), 32'(es));
        check({tag, " cout"}, 32'(get_cout(d)), 32'(ec));
        check({tag, " overflow"}, 32'(get_ovf(d)), 32'(eo));
        check({tag, " in_ready_done"}, 32'(get_ir(d)), 32'd0);
        set_ordy(d, 1'b1);
        @(negedge clk);
        set_ordy(d, 1'b0);
        check({tag, " out_valid_after"}, 32'(get_ov(d)), 32'd0);
        check({tag, " in_ready_after"}, 32'(get_ir(d)), 32'd1);
        $display("xact %s: a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d ovf=%0d lat=%0d",
                 tag, av, bv, c, get_sum(d), get_cout(d), get_ovf(d), lat);
    endtask

    initial begin
        logic [4:0]  full;
        logic [15:0] snap_sum;

        // Reset state, observed while reset is still held
        #1;
        check("rst in_ready", 32'(ir0), 32'd1);
        check("rst out_valid", 32'(ov0), 32'd0);
        check("rst sum", 32'(s0), 32'd0);
        check("rst cout", 32'(co0), 32'd0);
        check("rst overflow", 32'(of0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=16, CHUNK=4 directed vectors
        xact(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4, "w16_carry_chain");
        xact(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4, "w16_cin_wrap");
        xact(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "w16_pos_ovf");
        xact(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4, "w16_neg_ovf");
        xact(0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 4, "w16_plain");

        // Backpressure with operand toggling during RUN: 1234+1111 = 2345
        drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        drive(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("bp out_valid_enter", 32'(ov0), 32'd1);
        check("bp sum", 32'(s0), 32'h2345);
        snap_sum = s0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
            @(negedge clk);
            check("bp hold out_valid", 32'(ov0), 32'd1);
            check("bp hold in_ready", 32'(ir0), 32'd0);
            check("bp hold sum", 32'(s0), 32'(snap_sum));
            check("bp hold cout", 32'(co0), 32'd0);
            check("bp hold overflow", 32'(of0), 32'd0);
        end
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        set_ordy(0, 1'b1);
        @(negedge clk);
        set_ordy(0, 1'b0);
        check("bp release out_valid", 32'(ov0), 32'd0);
        check("bp release in_ready", 32'(ir0), 32'd1);
        check("bp release sum_kept", 32'(s0), 32'h2345);
        $display("xact bp: a=1234 b=1111 held 5 cycles -> sum=%0h", s0);

        // Reset pulse two cycles into RUN aborts immediately
        drive(0, 1'b1, 16'h00F0, 16'h0F00, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort pre in_ready", 32'(ir0), 32'd0);
        rst = 1'b1;
        #1;
        check("abort in_ready", 32'(ir0), 32'd1);
        check("abort out_valid", 32'(ov0), 32'd0);
        check("abort sum", 32'(s0), 32'd0);
        check("abort cout", 32'(co0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort idle out_valid", 32'(ov0), 32'd0);
        $display("xact abort: reset mid-RUN -> sum=%0h out_valid=%0d", s0, ov0);
        xact(0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 4, "w16_after_abort");

        // WIDTH=8, CHUNK=8: single-cycle RUN
        xact(2, 16'h00F0, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "w8_wrap");
        xact(2, 16'h007F, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b1, 1, "w8_cin_ovf");

        // WIDTH=4, CHUNK=1: every {a,b,cin}
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [3:0] av, bv;
                    logic       eo;
                    av   = 4'(ai);
                    bv   = 4'(bi);
                    full = 5'(ai) + 5'(bi) + 5'(ci);
                    eo   = (av[3] == bv[3]) && (full[3] != av[3]);
                    xact(1, {12'h000, av}, {12'h000, bv}, 1'(ci),
                         {12'h000, full[3:0]}, full[4], eo, 4,
                         $sformatf("w4_%0h_%0h_%0d", ai, bi, ci));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
